// File: rtl/timer_bank_pkg.sv
// Shared register map and bit positions for the timer bank.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package timer_bank_pkg;

  // Channel index is addr[7:4]; register offset is addr[3:0]
  localparam int CH_IDX_W = 4;
  localparam int OFF_W    = 4;

  // Register offsets within a channel
  localparam logic [OFF_W-1:0] OFF_CNT0 = 4'h0;  // count bytes 0..3 at 0x0..0x3
  localparam logic [OFF_W-1:0] OFF_RLD0 = 4'h4;  // reload bytes 0..3 at 0x4..0x7
  localparam logic [OFF_W-1:0] OFF_CTRL = 4'h8;
  localparam logic [OFF_W-1:0] OFF_STAT = 4'h9;

  // Control register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_PER     = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_RESTART = 3;  // write-only strobe, always reads 0

  // Status register bit positions
  localparam int STAT_FLAG = 0;

  // Pick byte idx out of a 32-bit word
  function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] idx);
    return v[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown timer channel: count, reload, snapshot, control bits and flag.
// Latency: CPU writes and tick effects land on the clock edge after they are presented.
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic [WIDTH/8-1:0] cnt_we,
  input  logic [WIDTH/8-1:0] rld_we,
  input  logic               ctrl_we,
  input  logic               stat_we,
  input  logic               snap_ld,
  input  logic [7:0]         wdat,
  output logic [WIDTH-1:0]   count,
  output logic [WIDTH-1:0]   reload,
  output logic [WIDTH-1:0]   snapshot,
  output logic               enable,
  output logic               periodic,
  output logic               irq_en,
  output logic               flag
);

  localparam int NB = WIDTH / 8;

  logic             cnt_wr;
  logic             restart;
  logic             cpu_load;
  logic             at_end;
  logic             expire;
  logic             dec;
  logic [WIDTH-1:0] cnt_wr_val;
  logic [WIDTH-1:0] rld_wr_val;

  // A CPU load of count (byte write or restart) masks the tick entirely,
  // including the flag, so software never races a half-applied expiry.
  assign cnt_wr   = |cnt_we;
  assign restart  = ctrl_we & wdat[CTRL_RESTART];
  assign cpu_load = cnt_wr | restart;
  assign at_end   = (count <= WIDTH'(1));
  assign expire   = tick & enable & at_end & ~cpu_load;
  assign dec      = tick & enable & ~at_end & ~cpu_load;

  // Merge the written byte into the current count/reload values
  always_comb begin
    cnt_wr_val = count;
    rld_wr_val = reload;
    for (int b = 0; b < NB; b++) begin
      if (cnt_we[b]) cnt_wr_val[b*8 +: 8] = wdat;
      if (rld_we[b]) rld_wr_val[b*8 +: 8] = wdat;
    end
  end

  // Count: CPU write > restart > expiry reload/clear > decrement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (cnt_wr) begin
      count <= cnt_wr_val;
    end else if (restart) begin
      count <= reload;
    end else if (expire) begin
      count <= periodic ? reload : '0;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  // Reload register and read-coherent snapshot of the full count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload   <= '0;
      snapshot <= '0;
    end else begin
      reload <= rld_wr_val;
      if (snap_ld) snapshot <= count;
    end
  end

  // Control bits: a write wins; otherwise a one-shot expiry drops enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
    end else if (ctrl_we) begin
      enable   <= wdat[CTRL_EN];
      periodic <= wdat[CTRL_PER];
      irq_en   <= wdat[CTRL_IRQ_EN];
    end else if (expire && !periodic) begin
      enable <= 1'b0;
    end
  end

  // Flag: set on expiry, write-1-to-clear; a same-cycle set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag <= 1'b0;
    end else if (expire) begin
      flag <= 1'b1;
    end else if (stat_we && wdat[STAT_FLAG]) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of CHANNELS countdown timers sharing one prescaler, with a byte-wide CPU port.
// Latency: dout is combinational on addr; writes apply on the next edge; tick is registered.
// Backpressure: none; CPU reads and writes always complete in a single cycle.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 24000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       tick,
  output logic       irq
);

  localparam int NB = WIDTH / 8;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       presc;
  logic [CH_IDX_W-1:0] ch_sel;
  logic [OFF_W-1:0]    offset;
  logic                wr_en;
  logic                rd_en;

  logic [WIDTH-1:0] ch_cnt  [CHANNELS];
  logic [WIDTH-1:0] ch_rld  [CHANNELS];
  logic [WIDTH-1:0] ch_snap [CHANNELS];
  logic [CHANNELS-1:0] ch_en;
  logic [CHANNELS-1:0] ch_per;
  logic [CHANNELS-1:0] ch_irq_en;
  logic [CHANNELS-1:0] ch_flag;

  assign ch_sel = addr[7:4];
  assign offset = addr[3:0];
  assign wr_en  = cs & wr;
  assign rd_en  = cs & rd;

  // Free-running prescaler; tick is registered so it is low for the first cycle out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == PW'(PRESCALE - 1)) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      tick  <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          ch_hit;
    logic [NB-1:0] cnt_we;
    logic [NB-1:0] rld_we;

    assign ch_hit = (ch_sel == CH_IDX_W'(c));

    for (genvar b = 0; b < NB; b++) begin : g_byte
      assign cnt_we[b] = wr_en & ch_hit & (offset == OFF_CNT0 + 4'(b));
      assign rld_we[b] = wr_en & ch_hit & (offset == OFF_RLD0 + 4'(b));
    end

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .cnt_we   (cnt_we),
      .rld_we   (rld_we),
      .ctrl_we  (wr_en & ch_hit & (offset == OFF_CTRL)),
      .stat_we  (wr_en & ch_hit & (offset == OFF_STAT)),
      .snap_ld  (rd_en & ch_hit & (offset == OFF_CNT0)),
      .wdat     (din),
      .count    (ch_cnt[c]),
      .reload   (ch_rld[c]),
      .snapshot (ch_snap[c]),
      .enable   (ch_en[c]),
      .periodic (ch_per[c]),
      .irq_en   (ch_irq_en[c]),
      .flag     (ch_flag[c])
    );
  end

  // Interrupt level: any channel with flag and irq_en both set
  assign irq = |(ch_flag & ch_irq_en);

  logic             ch_ok;
  logic [WIDTH-1:0] sel_cnt;
  logic [WIDTH-1:0] sel_rld;
  logic [WIDTH-1:0] sel_snap;
  logic [7:0]       ctrl_byte;
  logic [7:0]       stat_byte;
  logic [31:0]      cnt32;
  logic [31:0]      rld32;
  logic [31:0]      snap32;

  // Read mux: zero-extending to 32 bits makes bytes beyond WIDTH read 0x00
  always_comb begin
    ch_ok     = 1'b0;
    sel_cnt   = '0;
    sel_rld   = '0;
    sel_snap  = '0;
    ctrl_byte = '0;
    stat_byte = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel == CH_IDX_W'(c)) begin
        ch_ok                  = 1'b1;
        sel_cnt                = ch_cnt[c];
        sel_rld                = ch_rld[c];
        sel_snap               = ch_snap[c];
        ctrl_byte[CTRL_EN]     = ch_en[c];
        ctrl_byte[CTRL_PER]    = ch_per[c];
        ctrl_byte[CTRL_IRQ_EN] = ch_irq_en[c];
        stat_byte[STAT_FLAG]   = ch_flag[c];
      end
    end
    cnt32  = 32'(sel_cnt);
    rld32  = 32'(sel_rld);
    snap32 = 32'(sel_snap);
    dout   = '0;
    if (ch_ok) begin
      if (offset[3:2] == OFF_CNT0[3:2]) begin
        // Byte 0 is live; upper bytes come from the snapshot taken on the byte-0 read
        dout = (offset[1:0] == 2'b00) ? cnt32[7:0] : byte_sel(snap32, offset[1:0]);
      end else if (offset[3:2] == OFF_RLD0[3:2]) begin
        dout = byte_sel(rld32, offset[1:0]);
      end else if (offset == OFF_CTRL) begin
        dout = ctrl_byte;
      end else if (offset == OFF_STAT) begin
        dout = stat_byte;
      end
    end
  end

endmodule
